// File: rtl/l17_out_writer.sv
// l17_out_writer: buffers 16-lane result vectors in a 2-entry FIFO and writes them to consecutive BRAM addresses.
// Optional macro L17_OUT_RELU_EN clamps negative lanes to zero before buffering.
`default_nettype none

module l17_out_writer #(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 784
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic                             in_valid_i,
    input  logic [N_adder_tree*DATA_W-1:0]   in_data_i,
    output logic                             in_ready_o,
    input  logic                             bram_grant_i,
    output logic                             bram_we_o,
    output logic [ADDR_W-1:0]                bram_addr_o,
    output logic [N_adder_tree*DATA_W-1:0]   bram_din_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             overflow_err_o
);

    localparam int VEC_W = N_adder_tree * DATA_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     wcnt_q, wcnt_d;
    logic [1:0]           count_q, count_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [VEC_W-1:0]     din_q, din_d;
    logic                 ovf_q, ovf_d;
    logic [VEC_W-1:0]     fifo_q [2];

    logic                 run;
    logic                 ready;
    logic                 push;
    logic                 pop;
    logic                 stall;
    logic [VEC_W-1:0]     lanes_proc;

    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
`ifdef L17_OUT_RELU_EN
        assign lanes_proc[i*DATA_W +: DATA_W] =
            in_data_i[(i+1)*DATA_W-1] ? '0 : in_data_i[i*DATA_W +: DATA_W];
`else
        assign lanes_proc[i*DATA_W +: DATA_W] = in_data_i[i*DATA_W +: DATA_W];
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        wcnt_d   = wcnt_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        ovf_d    = ovf_q;

        run   = (state_q == S_RUN);
        ready = run && (count_q != 2'd2) && (acc_q < DEPTH_C);
        push  = in_valid_i && ready;
        pop   = run && (count_q != 2'd0) && bram_grant_i;
        // A full FIFO during an unfinished pass is back-pressure, not an error
        stall = run && (count_q == 2'd2) && (acc_q < DEPTH_C);

        if (in_valid_i && !ready && !stall) begin
            ovf_d = 1'b1;
        end

        if (pop) begin
            we_d     = 1'b1;
            addr_d   = wcnt_q[ADDR_W-1:0];
            din_d    = fifo_q[rd_ptr_q];
            rd_ptr_d = ~rd_ptr_q;
            wcnt_d   = wcnt_q + ONE_C;
        end

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
            acc_d    = acc_q + ONE_C;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    acc_d    = '0;
                    wcnt_d   = '0;
                    count_d  = 2'd0;
                    rd_ptr_d = 1'b0;
                    wr_ptr_d = 1'b0;
                end
            end
            S_RUN: begin
                if (pop && (wcnt_q == LAST_C)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            wcnt_q   <= '0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            wcnt_q   <= wcnt_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= lanes_proc;
        end
    end

    assign in_ready_o     = ready;
    assign bram_we_o      = we_q;
    assign bram_addr_o    = addr_q;
    assign bram_din_o     = din_q;
    assign busy_o         = (state_q == S_RUN);
    assign done_o         = (state_q == S_DONE);
    assign overflow_err_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_l17_out_writer.sv
// Self-checking bench for l17_out_writer (DEPTH=4, ADDR_W=2) against a queue-based reference model.
`default_nettype none

module tb_l17_out_writer;

    localparam int NL    = 16;
    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int VW    = NL * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [VW-1:0] in_data;
    logic          bram_grant;
    wire           in_ready;
    wire           bram_we;
    wire  [AW-1:0] bram_addr;
    wire  [VW-1:0] bram_din;
    wire           busy;
    wire           done;
    wire           overflow_err;

    l17_out_writer #(
        .N_adder_tree(NL),
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .in_valid_i    (in_valid),
        .in_data_i     (in_data),
        .in_ready_o    (in_ready),
        .bram_grant_i  (bram_grant),
        .bram_we_o     (bram_we),
        .bram_addr_o   (bram_addr),
        .bram_din_o    (bram_din),
        .busy_o        (busy),
        .done_o        (done),
        .overflow_err_o(overflow_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: pass phase, pending vectors, counts and expected outputs
    int            m_phase;  // 0 idle, 1 running, 2 done cycle
    logic [VW-1:0] m_q[$];
    int            m_acc;
    int            m_wr;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [VW-1:0] m_din;
    logic          m_ovf;
    logic          m_done_flag;
    int            dut_done;
    logic          relu_chk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < VW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_lanes(input logic [VW-1:0] d);
        logic [VW-1:0] r;
        r = d;
`ifdef L17_OUT_RELU_EN
        for (int l = 0; l < NL; l++)
            if ($signed(d[l*DW +: DW]) < 0) r[l*DW +: DW] = '0;
`endif
        return r;
    endfunction

    task automatic m_reset();
        m_phase = 0;
        m_q.delete();
        m_acc = 0;
        m_wr  = 0;
        m_we  = 1'b0;
        m_addr = '0;
        m_din = '0;
        m_ovf = 1'b0;
    endtask

    task automatic step(input logic s, input logic v, input logic g, input logic [VW-1:0] d);
        logic rdy;
        logic pu;
        logic po;
        @(negedge clk);
        start = s; in_valid = v; bram_grant = g; in_data = d;
        #1;
        rdy = (m_phase == 1) && (m_q.size() < 2) && (m_acc < DEPTH);
        chk("in_ready", in_ready, rdy);
        pu = v && rdy;
        po = (m_phase == 1) && (m_q.size() > 0) && g;
        if (v && !rdy && !((m_phase == 1) && (m_acc < DEPTH) && (m_q.size() == 2))) m_ovf = 1'b1;
        m_we = po;
        if (po) begin
            m_addr = AW'(m_wr);
            m_din  = m_q.pop_front();
            m_wr++;
        end
        if (pu) begin
            m_q.push_back(exp_lanes(d));
            m_acc++;
        end
        case (m_phase)
            0: if (s) begin m_phase = 1; m_acc = 0; m_wr = 0; end
            1: if (po && m_wr == DEPTH) m_phase = 2;
            default: m_phase = 0;
        endcase
        @(posedge clk);
        #1;
        chk("bram_we", bram_we, m_we);
        chk("bram_addr", bram_addr, m_addr);
        chk("bram_din", bram_din, m_din);
        chk("busy", busy, m_phase == 1);
        chk("done", done, m_phase == 2);
        chk("overflow_err", overflow_err, m_ovf);
        if (done) dut_done++;
        if (m_phase == 2) m_done_flag = 1'b1;
        if (relu_chk && m_we) begin
`ifdef L17_OUT_RELU_EN
            chk("relu_lane0", bram_din[15:0], 16'h0000);
`else
            chk("relu_lane0", bram_din[15:0], 16'h8001);
`endif
            chk("relu_lane1", bram_din[31:16], 16'h7FFF);
            relu_chk = 1'b0;
        end
    endtask

    task automatic finish_pass(input logic s);
        for (int k = 0; k < 40 && !m_done_flag; k++)
            step(s, (m_phase == 1) && (m_acc < DEPTH), 1'b1, rand_vec());
        chk("pass_done", m_done_flag, 1'b1);
        step(s, 1'b0, 1'b1, '0);
        chk("done_pulses", dut_done, 1);
        m_done_flag = 1'b0;
        dut_done = 0;
    endtask

    task automatic check_zero_outputs(input string ph);
        chk({ph, "_in_ready"}, in_ready, 1'b0);
        chk({ph, "_bram_we"}, bram_we, 1'b0);
        chk({ph, "_bram_addr"}, bram_addr, '0);
        chk({ph, "_bram_din"}, bram_din, '0);
        chk({ph, "_busy"}, busy, 1'b0);
        chk({ph, "_done"}, done, 1'b0);
        chk({ph, "_overflow"}, overflow_err, 1'b0);
    endtask

    initial begin
        logic [VW-1:0] rv;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; bram_grant = 1'b0; in_data = '0;
        m_done_flag = 1'b0; dut_done = 0; relu_chk = 1'b0;
        m_reset();
        @(negedge clk); @(negedge clk); #1;
        check_zero_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        // Back-to-back pass with grant held high
        step(1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, rand_vec());
        finish_pass(1'b0);

        // Grant withheld: exactly two vectors absorbed, no error
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, rand_vec());
        chk("stall_accepted", m_acc, 2);
        chk("stall_no_ovf", overflow_err, 1'b0);
        finish_pass(1'b0);

        // Negative-lane clamping on the first vector
        rv = rand_vec();
        rv[15:0] = 16'h8001;
        rv[31:16] = 16'h7FFF;
        relu_chk = 1'b1;
        step(1'b1, 1'b0, 1'b1, '0);
        step(1'b0, 1'b1, 1'b1, rv);
        finish_pass(1'b0);
        chk("relu_seen", relu_chk, 1'b0);

        // Random valid/grant pass
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 30 && !m_done_flag; i++)
            step(1'b0, ($urandom_range(0, 1) == 1) && (m_phase == 1) && (m_acc < DEPTH),
                 $urandom_range(0, 1) == 1, rand_vec());
        finish_pass(1'b0);

        // Reset after two writes aborts the pass
        step(1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 20 && m_wr < 2; i++) step(1'b0, m_acc < DEPTH, 1'b1, rand_vec());
        chk("writes_before_reset", m_wr, 2);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        m_reset();
        dut_done = 0;
        @(negedge clk); rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1, '0);
        finish_pass(1'b0);

        // Start held high across a pass, then a fresh pass from IDLE
        step(1'b1, 1'b0, 1'b1, '0);
        finish_pass(1'b1);
        step(1'b1, 1'b0, 1'b1, '0);
        finish_pass(1'b0);

        // Overflow: valid in IDLE, then a fifth vector beyond DEPTH
        step(1'b0, 1'b1, 1'b0, rand_vec());
        chk("ovf_idle", overflow_err, 1'b1);
        step(1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, rand_vec());
        finish_pass(1'b0);
        chk("ovf_sticky", overflow_err, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
